// File: rtl/aes_output_buffer.sv
// aes_output_buffer: captures 128-bit cipher results on done_i into a DEPTH-entry
// FIFO and streams each result as four 32-bit words (MS word first) over a
// valid/ready handshake. Reports back-pressure (full_o) and dropped results.
// Optional build macro: AES_OBUF_OVF_CNT_EN enables the 8-bit saturating drop
// counter on ovf_cnt_o; without it ovf_cnt_o is tied to 0.
module aes_output_buffer #(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     done_i,
  input  logic [127:0]             text_i,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [31:0]              word_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic                     last_o,
  output logic                     ovf_o,
  input  logic                     clr_ovf_i,
  output logic [7:0]               ovf_cnt_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic {EMPTY, SEND} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [1:0]      widx_q, widx_d;
  logic            ovf_q, ovf_d;
  logic [127:0]    mem_q [DEPTH];

  logic            full, xfer, pop, push, drop;
  logic [127:0]    head;

  // Handshake events; a completing pop frees a slot for a same-cycle push.
  always_comb begin
    full = (count_q == CW'(DEPTH));
    xfer = (state_q == SEND) && ready_i;
    pop  = xfer && (widx_q == 2'd3);
    push = done_i && (!full || pop);
    drop = done_i && full && !pop;
  end

  // Next-state: pointers, occupancy, word index, sender FSM and sticky flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    widx_d   = widx_q;
    state_d  = state_q;
    ovf_d    = ovf_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (xfer) widx_d = widx_q + 2'd1;

    case (state_q)
      EMPTY:   if (count_d != '0) state_d = SEND;
      SEND:    if (pop && (count_d == '0)) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase

    if (clr_ovf_i)  ovf_d = 1'b0;
    else if (drop)  ovf_d = 1'b1;
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= EMPTY;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      widx_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      widx_q   <= widx_d;
      ovf_q    <= ovf_d;
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= text_i;
  end

`ifdef AES_OBUF_OVF_CNT_EN
  logic [7:0] ovf_cnt_q, ovf_cnt_d;

  // Saturating drop counter; clear wins over a same-cycle drop.
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (clr_ovf_i)                       ovf_cnt_d = '0;
    else if (drop && (ovf_cnt_q != '1))  ovf_cnt_d = ovf_cnt_q + 8'd1;
  end

  // Drop counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ovf_cnt_q <= '0;
    else      ovf_cnt_q <= ovf_cnt_d;
  end

  assign ovf_cnt_o = ovf_cnt_q;
`else
  assign ovf_cnt_o = '0;
`endif

  // Outputs decoded purely from registered state (no input-to-output path).
  always_comb begin
    head    = mem_q[rd_ptr_q];
    valid_o = (state_q == SEND);
    word_o  = '0;
    if (valid_o) begin
      case (widx_q)
        2'd0:    word_o = head[127:96];
        2'd1:    word_o = head[95:64];
        2'd2:    word_o = head[63:32];
        default: word_o = head[31:0];
      endcase
    end
    last_o  = valid_o && (widx_q == 2'd3);
    full_o  = full;
    count_o = count_q;
    ovf_o   = ovf_q;
  end

endmodule

// File: tb/tb_aes_output_buffer.sv
// Directed self-checking bench for aes_output_buffer (DEPTH = 2).
module tb_aes_output_buffer;

  localparam int unsigned DEPTH = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         done_i = 1'b0;
  logic [127:0] text_i = '0;
  logic         full_o;
  logic [1:0]   count_o;
  logic [31:0]  word_o;
  logic         valid_o;
  logic         ready_i = 1'b0;
  logic         last_o;
  logic         ovf_o;
  logic         clr_ovf_i = 1'b0;
  logic [7:0]   ovf_cnt_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [127:0] blk_a = 128'h3925841d02dc09fbdc118597196a0b32;
  logic [127:0] blk_b = 128'h00112233445566778899aabbccddeeff;
  logic [127:0] blk_c = 128'hdeadbeef0badf00dcafebabe12345678;
  logic [31:0]  exp1 [4] = '{32'h3925841d, 32'h02dc09fb, 32'hdc118597, 32'h196a0b32};

`ifdef AES_OBUF_OVF_CNT_EN
  localparam logic [7:0] CNT_ONE = 8'd1;
  localparam logic [7:0] CNT_SAT = 8'd255;
`else
  localparam logic [7:0] CNT_ONE = 8'd0;
  localparam logic [7:0] CNT_SAT = 8'd0;
`endif

  aes_output_buffer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .done_i    (done_i),
    .text_i    (text_i),
    .full_o    (full_o),
    .count_o   (count_o),
    .word_o    (word_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .last_o    (last_o),
    .ovf_o     (ovf_o),
    .clr_ovf_i (clr_ovf_i),
    .ovf_cnt_o (ovf_cnt_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] wsel(input logic [127:0] b, input int i);
    logic [127:0] s;
    s = b << (32 * i);
    return s[127:96];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    total_cnt++;
    if ({full_o, count_o, word_o, valid_o, last_o, ovf_o, ovf_cnt_o} !== '0)
      $display("FAIL reset_state: got full=%b cnt=%0d word=%h v=%b l=%b ovf=%b oc=%0d exp all 0",
               full_o, count_o, word_o, valid_o, last_o, ovf_o, ovf_cnt_o);
    else pass_cnt++;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single();
    done_i = 1'b1; text_i = blk_a; ready_i = 1'b1;
    tick();
    done_i = 1'b0;
    total_cnt++;
    if (count_o !== 2'd1)
      $display("FAIL single_count: got %0d exp 1", count_o);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if ({valid_o, last_o, word_o} !== {1'b1, (i == 3) ? 1'b1 : 1'b0, exp1[i]})
        $display("FAIL single_word%0d: got v=%b l=%b w=%h exp v=1 l=%0d w=%h",
                 i, valid_o, last_o, word_o, (i == 3), exp1[i]);
      else pass_cnt++;
      tick();
    end
    total_cnt++;
    if ({valid_o, last_o, word_o, count_o} !== '0)
      $display("FAIL single_drain: got v=%b l=%b w=%h cnt=%0d exp all 0",
               valid_o, last_o, word_o, count_o);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    done_i = 1'b1; text_i = blk_a; ready_i = 1'b1;
    tick();
    done_i = 1'b0;
    total_cnt++;
    if ({valid_o, word_o} !== {1'b1, 32'h3925841d})
      $display("FAIL bp_word0: got v=%b w=%h exp v=1 w=3925841d", valid_o, word_o);
    else pass_cnt++;
    tick();
    ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if ({valid_o, last_o, word_o} !== {2'b10, 32'h02dc09fb})
        $display("FAIL bp_hold%0d: got v=%b l=%b w=%h exp v=1 l=0 w=02dc09fb",
                 i, valid_o, last_o, word_o);
      else pass_cnt++;
      if (i < 3) tick();
    end
    ready_i = 1'b1;
    for (int i = 2; i < 4; i++) begin
      tick();
      total_cnt++;
      if ({valid_o, last_o, word_o} !== {1'b1, (i == 3) ? 1'b1 : 1'b0, exp1[i]})
        $display("FAIL bp_word%0d: got v=%b l=%b w=%h exp w=%h", i, valid_o, last_o, word_o, exp1[i]);
      else pass_cnt++;
    end
    tick();
    total_cnt++;
    if ({valid_o, count_o} !== '0)
      $display("FAIL bp_drain: got v=%b cnt=%0d exp 0 0", valid_o, count_o);
    else pass_cnt++;
  endtask

  task automatic test_overflow();
    logic [127:0] b;
    ready_i = 1'b0;
    done_i = 1'b1; text_i = blk_a;
    tick();
    text_i = blk_b;
    tick();
    total_cnt++;
    if ({full_o, count_o, ovf_o} !== {1'b1, 2'd2, 1'b0})
      $display("FAIL ovf_full: got full=%b cnt=%0d ovf=%b exp 1 2 0", full_o, count_o, ovf_o);
    else pass_cnt++;
    text_i = blk_c;
    tick();
    done_i = 1'b0;
    total_cnt++;
    if ({ovf_o, ovf_cnt_o, count_o} !== {1'b1, CNT_ONE, 2'd2})
      $display("FAIL ovf_drop: got ovf=%b oc=%0d cnt=%0d exp 1 %0d 2", ovf_o, ovf_cnt_o, count_o, CNT_ONE);
    else pass_cnt++;
    ready_i = 1'b1;
    for (int n = 0; n < 8; n++) begin
      b = (n < 4) ? blk_a : blk_b;
      total_cnt++;
      if ({valid_o, last_o, word_o} !== {1'b1, (n % 4 == 3) ? 1'b1 : 1'b0, wsel(b, n % 4)})
        $display("FAIL ovf_word%0d: got v=%b l=%b w=%h exp w=%h", n, valid_o, last_o, word_o, wsel(b, n % 4));
      else pass_cnt++;
      tick();
    end
    total_cnt++;
    if ({valid_o, count_o, ovf_o} !== {1'b0, 2'd0, 1'b1})
      $display("FAIL ovf_drain: got v=%b cnt=%0d ovf=%b exp 0 0 1", valid_o, count_o, ovf_o);
    else pass_cnt++;
    clr_ovf_i = 1'b1;
    tick();
    clr_ovf_i = 1'b0;
    total_cnt++;
    if ({ovf_o, ovf_cnt_o} !== '0)
      $display("FAIL ovf_clear: got ovf=%b oc=%0d exp 0 0", ovf_o, ovf_cnt_o);
    else pass_cnt++;
  endtask

  task automatic test_push_pop_full();
    logic [127:0] b;
    ready_i = 1'b0;
    done_i = 1'b1; text_i = blk_a;
    tick();
    text_i = blk_b;
    tick();
    done_i = 1'b0;
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if ({valid_o, word_o} !== {1'b1, wsel(blk_a, i)})
        $display("FAIL pp_a%0d: got v=%b w=%h exp w=%h", i, valid_o, word_o, wsel(blk_a, i));
      else pass_cnt++;
      if (i == 3) begin
        done_i = 1'b1; text_i = blk_c;
      end
      tick();
    end
    done_i = 1'b0;
    total_cnt++;
    if ({ovf_o, count_o, full_o} !== {1'b0, 2'd2, 1'b1})
      $display("FAIL pp_accept: got ovf=%b cnt=%0d full=%b exp 0 2 1", ovf_o, count_o, full_o);
    else pass_cnt++;
    for (int n = 0; n < 8; n++) begin
      b = (n < 4) ? blk_b : blk_c;
      total_cnt++;
      if ({valid_o, last_o, word_o} !== {1'b1, (n % 4 == 3) ? 1'b1 : 1'b0, wsel(b, n % 4)})
        $display("FAIL pp_word%0d: got v=%b l=%b w=%h exp w=%h", n, valid_o, last_o, word_o, wsel(b, n % 4));
      else pass_cnt++;
      tick();
    end
    total_cnt++;
    if ({valid_o, count_o} !== '0)
      $display("FAIL pp_drain: got v=%b cnt=%0d exp 0 0", valid_o, count_o);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    done_i = 1'b1; text_i = blk_a; ready_i = 1'b1;
    tick();
    done_i = 1'b0;
    tick();
    total_cnt++;
    if (word_o !== 32'h02dc09fb)
      $display("FAIL rm_word1: got %h exp 02dc09fb", word_o);
    else pass_cnt++;
    rst = 1'b0;
    #1;
    total_cnt++;
    if ({full_o, count_o, word_o, valid_o, last_o, ovf_o, ovf_cnt_o} !== '0)
      $display("FAIL rm_async: got cnt=%0d w=%h v=%b l=%b exp all 0", count_o, word_o, valid_o, last_o);
    else pass_cnt++;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++;
      if ({valid_o, word_o, count_o} !== '0)
        $display("FAIL rm_idle%0d: got v=%b w=%h cnt=%0d exp 0", i, valid_o, word_o, count_o);
      else pass_cnt++;
    end
  endtask

  task automatic test_clear_priority();
    ready_i = 1'b0;
    done_i = 1'b1; text_i = blk_a;
    tick();
    text_i = blk_b;
    tick();
    text_i = blk_c; clr_ovf_i = 1'b1;
    tick();
    done_i = 1'b0; clr_ovf_i = 1'b0;
    total_cnt++;
    if ({ovf_o, ovf_cnt_o, count_o} !== {1'b0, 8'd0, 2'd2})
      $display("FAIL clr_prio: got ovf=%b oc=%0d cnt=%0d exp 0 0 2", ovf_o, ovf_cnt_o, count_o);
    else pass_cnt++;
    done_i = 1'b1;
    repeat (300) tick();
    done_i = 1'b0;
    total_cnt++;
    if ({ovf_o, ovf_cnt_o} !== {1'b1, CNT_SAT})
      $display("FAIL clr_sat: got ovf=%b oc=%0d exp 1 %0d", ovf_o, ovf_cnt_o, CNT_SAT);
    else pass_cnt++;
    clr_ovf_i = 1'b1;
    tick();
    clr_ovf_i = 1'b0;
    ready_i = 1'b1;
    repeat (8) tick();
    total_cnt++;
    if ({ovf_o, ovf_cnt_o, count_o, valid_o} !== '0)
      $display("FAIL clr_after: got ovf=%b oc=%0d cnt=%0d v=%b exp 0", ovf_o, ovf_cnt_o, count_o, valid_o);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_overflow();
    test_push_pop_full();
    test_reset_mid();
    test_clear_priority();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
